// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle control unit.
// Opcodes, state codes and datapath select codes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_INIT = 4'd0,
    S_IF   = 4'd1,
    S_ID   = 4'd2,
    S_MA   = 4'd3,
    S_MRD  = 4'd4,
    S_MWR  = 4'd5,
    S_WBL  = 4'd6,
    S_EXR  = 4'd7,
    S_WBR  = 4'd8,
    S_EXI  = 4'd9,
    S_WBI  = 4'd10,
    S_BR   = 4'd11,
    S_JMP  = 4'd12
  } state_e;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_ADDIU = 2'b11;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_SL2  = 2'b11;

  localparam logic [1:0] PCSRC_ALU = 2'b00;
  localparam logic [1:0] PCSRC_OUT = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  // States that wait on a memory access.
  function automatic logic is_mem_state(
    input state_e s
  );
    return (s == S_IF) || (s == S_MRD) ||
           (s == S_MWR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory completion generator.
// Handshake mode uses Mem_Ready; fixed mode counts cycles.
module mem_wait_timer #(
  parameter int MEM_MODE = 0,
  parameter int MEM_LAT  = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic active_i,
  input  logic leave_i,
  input  logic mem_ready_i,
  output logic done_o
);

  localparam logic [3:0] LAST = 4'(MEM_LAT - 1);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic       hit;

  // Cycle counter restarts whenever the state is left.
  always_comb begin
    cnt_d = cnt_q;
    if (!active_i || leave_i) begin
      cnt_d = '0;
    end else if (MEM_MODE != 0) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Wait counter register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit    = (cnt_q == LAST);
  assign done_o = active_i &
                  ((MEM_MODE == 0) ? mem_ready_i : hit);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control FSM.
// Moore-style strobes plus retired-instruction counter.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_MODE = 0,
  parameter int MEM_LAT  = 2,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [5:0]       Op,
  input  logic             Zero,
  input  logic             Mem_Ready,
  output logic             PCWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             Illegal,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] InstRet
);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] ret_q;
  logic [CNT_W-1:0] ret_d;
  logic             mem_done;
  logic             leave;
  logic             retire;

  assign leave = (state_d != state_q);

  mem_wait_timer #(
    .MEM_MODE (MEM_MODE),
    .MEM_LAT  (MEM_LAT)
  ) u_timer (
    .clk         (clk),
    .resetn      (resetn),
    .active_i    (is_mem_state(state_q)),
    .leave_i     (leave),
    .mem_ready_i (Mem_Ready),
    .done_o      (mem_done)
  );

  // Next state and per-state control strobes.
  always_comb begin
    state_d  = state_q;
    PCWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    MemtoReg = 1'b0;
    RegDst   = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SRCB_RT;
    ALUOp    = ALU_ADD;
    PCSource = PCSRC_ALU;
    Illegal  = 1'b0;
    unique case (state_q)
      S_INIT: state_d = S_IF;
      S_IF: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        if (mem_done) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_ID;
        end
      end
      S_ID: begin
        ALUSrcB = SRCB_SL2;
        case (Op)
          OP_LW, OP_SW:   state_d = S_MA;
          OP_SPECIAL:     state_d = S_EXR;
          OP_ADDIU:       state_d = S_EXI;
          OP_BEQ, OP_BNE: state_d = S_BR;
          OP_J:           state_d = S_JMP;
          default: begin
            Illegal = 1'b1;
            state_d = S_IF;
          end
        endcase
      end
      S_MA: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = (Op == OP_SW) ? S_MWR : S_MRD;
      end
      S_MRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_done) state_d = S_WBL;
      end
      S_MWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_done) state_d = S_IF;
      end
      S_WBL: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = S_IF;
      end
      S_EXR: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_FUNCT;
        state_d = S_WBR;
      end
      S_WBR: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        state_d  = S_IF;
      end
      S_EXI: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALU_ADDIU;
        state_d = S_WBI;
      end
      S_WBI: begin
        RegWrite = 1'b1;
        state_d  = S_IF;
      end
      S_BR: begin
        ALUSrcA  = 1'b1;
        ALUOp    = ALU_SUB;
        PCSource = PCSRC_OUT;
        PCWrite  = (Op == OP_BNE) ? ~Zero : Zero;
        state_d  = S_IF;
      end
      S_JMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JMP;
        state_d  = S_IF;
      end
      default: state_d = S_INIT;
    endcase
  end

  // An instruction retires when its last state hands back to fetch.
  always_comb begin
    retire = 1'b0;
    if (state_d == S_IF) begin
      retire = (state_q == S_WBL) || (state_q == S_MWR) ||
               (state_q == S_WBR) || (state_q == S_WBI) ||
               (state_q == S_BR)  || (state_q == S_JMP);
    end
    ret_d = retire ? ret_q + CNT_W'(1) : ret_q;
  end

  // State and retire counter registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_INIT;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
    end
  end

  assign State   = state_q;
  assign InstRet = ret_q;

endmodule
